// File: rtl/clk_disp_pkg.sv
// Shared definitions for the clock/display stage: field selects, glyphs, decoder.
package clk_disp_pkg;

  localparam int unsigned BCD_W  = 8;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned IDX_W  = 3;

  // Field select encodings for set mode
  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HR   = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // BCD nibble to glyph; non-decimal nibbles show blank
  function automatic logic [SEG_W-1:0] bcd2seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd2seg = SEG_0;
      4'd1:    bcd2seg = SEG_1;
      4'd2:    bcd2seg = SEG_2;
      4'd3:    bcd2seg = SEG_3;
      4'd4:    bcd2seg = SEG_4;
      4'd5:    bcd2seg = SEG_5;
      4'd6:    bcd2seg = SEG_6;
      4'd7:    bcd2seg = SEG_7;
      4'd8:    bcd2seg = SEG_8;
      4'd9:    bcd2seg = SEG_9;
      default: bcd2seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD counter that wraps to 00 after reaching max.
//   clkin, rst_n : clock, async active-low reset
//   inc          : advance one count this cycle
//   max          : BCD terminal value
//   q            : current BCD value (registered)
//   wrap         : combinational, inc && q == max
module bcd_mod_cnt
  import clk_disp_pkg::*;
(
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] q,
  output logic             wrap
);

  assign wrap = inc && (q == max);

  // Units 9 -> 0 carries into tens; terminal value returns to 00
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc) begin
      if (q == max)           q      <= '0;
      else if (q[3:0] == 4'd9) q      <= {q[7:4] + 4'd1, 4'd0};
      else                    q[3:0] <= q[3:0] + 4'd1;
    end
  end

endmodule

// File: rtl/hms_scan_core.sv
// HH:MM:SS BCD timekeeper with set mode and a six-digit multiplexed 7-seg scan.
//   clkin, rst_n        : clock, async active-low reset
//   tick_sec, tick_scan : one-cycle strobes (1 Hz, digit scan)
//   set_en/set_sel/set_inc : manual set mode, field select, field increment
//   sec_bcd/min_bcd/hr_bcd : current time, BCD
//   day_pulse           : one cycle after 23:59:59 -> 00:00:00
//   dig_n, seg_n        : active-low digit enable and segments
module hms_scan_core
  import clk_disp_pkg::*;
#(
  parameter logic [7:0]  HOUR_MAX = 8'h23,
  parameter logic [7:0]  MIN_MAX  = 8'h59,
  parameter int unsigned NDIG     = 6
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             tick_sec,
  input  logic             tick_scan,
  input  logic             set_en,
  input  logic [1:0]       set_sel,
  input  logic             set_inc,
  output logic [BCD_W-1:0] sec_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] hr_bcd,
  output logic             day_pulse,
  output logic [NDIG-1:0]  dig_n,
  output logic [SEG_W-1:0] seg_n
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  logic             tick_ok_c, edit_c;
  logic             sec_inc_c, min_inc_c, hr_inc_c;
  logic             sec_wrap, min_wrap, hr_wrap;
  logic             blink;
  logic [IDX_W-1:0] idx, idx_nxt_c;
  logic [3:0]       nib_c;
  logic             blank_c;

  // Ticks only count outside set mode; edits only apply inside it
  assign tick_ok_c = tick_sec & ~set_en;
  assign edit_c    = set_en & set_inc;
  assign sec_inc_c = tick_ok_c | (edit_c && set_sel == SEL_SEC);
  assign min_inc_c = (sec_wrap & ~set_en) | (edit_c && set_sel == SEL_MIN);
  assign hr_inc_c  = (min_wrap & ~set_en) | (edit_c && set_sel == SEL_HR);

  bcd_mod_cnt u_sec (.clkin(clkin), .rst_n(rst_n), .inc(sec_inc_c), .max(MIN_MAX),
                     .q(sec_bcd), .wrap(sec_wrap));
  bcd_mod_cnt u_min (.clkin(clkin), .rst_n(rst_n), .inc(min_inc_c), .max(MIN_MAX),
                     .q(min_bcd), .wrap(min_wrap));
  bcd_mod_cnt u_hr  (.clkin(clkin), .rst_n(rst_n), .inc(hr_inc_c),  .max(HOUR_MAX),
                     .q(hr_bcd),  .wrap(hr_wrap));

  // Next scan position and the nibble/blanking it will show
  always_comb begin
    idx_nxt_c = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    case (idx_nxt_c)
      3'd0:    nib_c = sec_bcd[3:0];
      3'd1:    nib_c = sec_bcd[7:4];
      3'd2:    nib_c = min_bcd[3:0];
      3'd3:    nib_c = min_bcd[7:4];
      3'd4:    nib_c = hr_bcd[3:0];
      default: nib_c = hr_bcd[7:4];
    endcase
    blank_c = set_en && blink && (set_sel != SEL_NONE) &&
              (set_sel == 2'(idx_nxt_c >> 1));
  end

  // Day pulse, blink phase and scan outputs
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      day_pulse <= 1'b0;
      blink     <= 1'b0;
      idx       <= '0;
      dig_n     <= ~NDIG'(1);
      seg_n     <= SEG_0;
    end else begin
      day_pulse <= hr_wrap & ~set_en;
      if (tick_sec) blink <= ~blink;
      if (tick_scan) begin
        idx   <= idx_nxt_c;
        dig_n <= ~(NDIG'(1) << idx_nxt_c);
        seg_n <= blank_c ? SEG_BLANK : bcd2seg(nib_c);
      end
    end
  end

endmodule

// File: tb/tb_hms_scan_core.sv
// Scoreboard bench for hms_scan_core: driver queues expectations, monitor checks at negedge.
module tb_hms_scan_core;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_sec = 1'b0, tick_scan = 1'b0, set_en = 1'b0, set_inc = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       day_pulse;
  logic [5:0] dig_n;
  logic [6:0] seg_n;

  hms_scan_core dut (
    .clkin(clkin), .rst_n(rst_n), .tick_sec(tick_sec), .tick_scan(tick_scan),
    .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd), .day_pulse(day_pulse),
    .dig_n(dig_n), .seg_n(seg_n)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    string       name;
    int          kind;   // 0 time, 1 day_pulse, 2 display
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Active-low glyphs {g,f,e,d,c,b,a}
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [5:0] one6 = 6'b000001;

  // Monitor: drain queued expectations; also check one-hot digit enable
  always @(negedge clkin) begin
    n_checks++;
    if ($countones(~dig_n) != 1) begin
      n_fail++;
      $display("FAIL dig_onehot: dig_n=%b needs exactly one zero bit", dig_n);
    end
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      n_checks++;
      case (cur.kind)
        0: if ({hr_bcd, min_bcd, sec_bcd} !== cur.val) begin
             n_fail++;
             $display("FAIL %s: time %h:%h:%h, expected %h", cur.name,
                      hr_bcd, min_bcd, sec_bcd, cur.val);
           end
        1: if (day_pulse !== cur.val[0]) begin
             n_fail++;
             $display("FAIL %s: day_pulse %b, expected %b", cur.name, day_pulse, cur.val[0]);
           end
        default: if ({dig_n, seg_n} !== cur.val[12:0]) begin
             n_fail++;
             $display("FAIL %s: dig_n=%b seg_n=%b, expected dig_n=%b seg_n=%b", cur.name,
                      dig_n, seg_n, cur.val[12:7], cur.val[6:0]);
           end
      endcase
    end
  end

  task automatic push(input string name, input int kind, input logic [23:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk_time(input string name, input logic [23:0] hms);
    push(name, 0, hms);
  endtask

  task automatic chk_disp(input string name, input logic [5:0] d, input logic [6:0] s);
    push(name, 2, {11'd0, d, s});
  endtask

  // One clock of stimulus; strobes are dropped right after the edge
  task automatic step(input bit ts, input bit tsc, input bit se, input logic [1:0] sel,
                      input bit si, input bit day_exp);
    @(negedge clkin);
    tick_sec = ts; tick_scan = tsc; set_en = se; set_sel = sel; set_inc = si;
    @(posedge clkin);
    #1;
    tick_sec = 1'b0; tick_scan = 1'b0; set_inc = 1'b0;
    push("day_pulse", 1, 24'(day_exp));
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst_n = 1'b0; tick_sec = 1'b0; tick_scan = 1'b0; set_en = 1'b0; set_inc = 1'b0;
    set_sel = 2'd3;
    @(negedge clkin);
    rst_n = 1'b1;
  endtask

  task automatic set_field(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, sel, 1'b1, 1'b0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_field(2'd2, h);
    set_field(2'd1, m);
    set_field(2'd0, s);
    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
  endtask

  int dig_tab [6] = '{6, 5, 4, 3, 2, 1};   // digits of 12:34:56, sec units first

  initial begin
    // Reset state and 60 seconds of counting
    do_reset();
    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_time("reset_time", 24'h000000);
    chk_disp("reset_disp", 6'b111110, 7'b1000000);
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
      if (i == 1)  chk_time("sec_1", 24'h000001);
      if (i == 10) chk_time("sec_10", 24'h000010);
      if (i == 59) chk_time("sec_59", 24'h000059);
      if (i == 60) chk_time("min_carry", 24'h000100);
    end

    // Day rollover
    do_reset();
    set_time(23, 59, 58);
    chk_time("preload_235958", 24'h235958);
    step(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_time("t_235959", 24'h235959);
    step(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
    chk_time("day_wrap", 24'h000000);
    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);

    // Set mode: hour wrap without carry, frozen ticks, sel none, sec wrap without carry
    set_field(2'd2, 21);
    chk_time("set_hr21", 24'h210000);
    set_field(2'd2, 5);
    chk_time("set_hr_wrap", 24'h020000);
    step(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    chk_time("set_tick_drop", 24'h020000);
    step(1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    chk_time("set_sel_none", 24'h020000);
    set_field(2'd0, 60);
    chk_time("set_sec_nocarry", 24'h020000);

    // Simultaneous events
    step(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    chk_time("tick_beats_inc", 24'h020001);
    step(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk_time("set_rise_drop", 24'h020001);
    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_time("resume_count", 24'h020002);

    // Scan of 12:34:56
    do_reset();
    set_time(12, 34, 56);
    chk_time("preload_123456", 24'h123456);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
      chk_disp("scan_warm", ~(one6 << i), glyph[dig_tab[i]]);
    end
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
      chk_disp("scan", ~(one6 << (k % 6)), glyph[dig_tab[k % 6]]);
      step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
      chk_disp("scan_hold", ~(one6 << (k % 6)), glyph[dig_tab[k % 6]]);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_disp("scan_pre_inc", 6'b111110, glyph[6]);
    chk_time("scan_tick_time", 24'h123457);
    // Blink phase is now 1: selected field blanks in set mode
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    chk_disp("blink_other", 6'b111101, glyph[5]);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_disp("blink_blank", 6'b111011, 7'h7F);
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    chk_disp("blink_min_tens", 6'b110111, glyph[3]);
    chk_time("blink_frozen", 24'h123457);

    // Asynchronous reset mid-scan
    do_reset();
    set_time(10, 20, 30);
    step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_disp("pre_rst_disp", 6'b111011, glyph[0]);
    chk_time("pre_rst_time", 24'h102030);
    step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    chk_disp("pre_rst_disp2", 6'b110111, glyph[2]);
    @(posedge clkin);
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("async_rst_time", 24'h000000);
    chk_disp("async_rst_disp", 6'b111110, 7'b1000000);
    push("async_rst_day", 1, 24'd0);
    @(negedge clkin);
    @(negedge clkin);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
    @(negedge clkin);
    @(negedge clkin);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
